axi_rd_arbiter: RTL and testbench

- Parametrised N-master to 1-slave AXI-lite read-channel arbiter for the core interconnect; it generalises the single-master read path.
- Typical use: IFU and LSU sharing one memory/SoC read port.
- Each transaction is arbitrated, its address is registered toward the slave, and the R response is routed back to the granted master.
- One outstanding transaction at a time.

---
 rtl/axi_rd_arbiter.sv | 115 +++++++++++
 tb/tb_axi_rd_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// N-master to 1-slave AXI-lite read-channel arbiter with one outstanding transaction.
// Define ICN_RR_ARB_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module axi_rd_arbiter #(
    parameter int NUM_MST = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_MST-1:0]          m_ar_valid,
    input  logic [NUM_MST*ADDR_W-1:0]   m_ar_addr,
    output logic [NUM_MST-1:0]          m_ar_ready,
    output logic [NUM_MST-1:0]          m_r_valid,
    output logic [DATA_W-1:0]           m_r_data,
    output logic [1:0]                  m_r_resp,
    input  logic [NUM_MST-1:0]          m_r_ready,
    output logic                        s_ar_valid,
    output logic [ADDR_W-1:0]           s_ar_addr,
    input  logic                        s_ar_ready,
    input  logic                        s_r_valid,
    input  logic [DATA_W-1:0]           s_r_data,
    input  logic [1:0]                  s_r_resp,
    output logic                        s_r_ready
);
    localparam int GNT_W = $clog2(NUM_MST);

    typedef enum logic [1:0] {ST_ARB, ST_ADDR, ST_RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [GNT_W-1:0]  gnt_q;
    logic [GNT_W-1:0]  sel;
    logic              any_req;
    logic              ar_hs;

`ifdef ICN_RR_ARB_EN
    logic [GNT_W-1:0]  last_q;
    logic [GNT_W-1:0]  cand;

    // Walk the search order backwards so the first candidate after last_q overwrites the rest.
    always_comb begin
        sel  = '0;
        cand = '0;
        for (int k = NUM_MST; k >= 1; k--) begin
            cand = GNT_W'((int'(last_q) + k) % NUM_MST);
            if (m_ar_valid[cand]) sel = cand;
        end
    end
`else
    always_comb begin
        sel = '0;
        for (int i = NUM_MST - 1; i >= 0; i--) begin
            if (m_ar_valid[i]) sel = GNT_W'(i);
        end
    end
`endif

    assign any_req = |m_ar_valid;
    // Ready is only ever raised toward a valid master, so being in ARB with a request is the handshake.
    assign ar_hs   = (state_q == ST_ARB) && any_req;

    assign s_ar_addr = addr_q;
    assign m_r_data  = s_r_data;
    assign m_r_resp  = s_r_resp;

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        m_ar_ready = '0;
        m_r_valid  = '0;
        s_ar_valid = 1'b0;
        s_r_ready  = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (any_req) begin
                    m_ar_ready[sel] = 1'b1;
                    state_d         = ST_ADDR;
                end
            end
            ST_ADDR: begin
                s_ar_valid = 1'b1;
                if (s_ar_ready) state_d = ST_RESP;
            end
            ST_RESP: begin
                s_r_ready        = m_r_ready[gnt_q];
                m_r_valid[gnt_q] = s_r_valid;
                if (s_r_valid && m_r_ready[gnt_q]) state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ARB;
            addr_q  <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ar_hs) begin
                addr_q <= m_ar_addr[int'(sel)*ADDR_W +: ADDR_W];
                gnt_q  <= sel;
            end
        end
    end

`ifdef ICN_RR_ARB_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)      last_q <= GNT_W'(NUM_MST - 1);
        else if (ar_hs) last_q <= sel;
    end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Table-driven bench for axi_rd_arbiter (2 masters) plus a 3-master round-robin wrap sequence.
// Expectations follow ICN_RR_ARB_EN the same way the design does.
module tb_axi_rd_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

`ifdef ICN_RR_ARB_EN
    localparam logic [1:0]    ALT_G  = 2'b10;
    localparam logic [31:0]   ALT_A  = 32'h200;
    localparam logic [2:0]    WRAP_G = 3'b100;
    localparam logic [31:0]   WRAP_A = 32'hC00;
`else
    localparam logic [1:0]    ALT_G  = 2'b01;
    localparam logic [31:0]   ALT_A  = 32'h100;
    localparam logic [2:0]    WRAP_G = 3'b001;
    localparam logic [31:0]   WRAP_A = 32'hA00;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Two-master instance
    logic [1:0]      m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;
    logic [2*AW-1:0] m_ar_addr;
    logic [DW-1:0]   m_r_data, s_r_data;
    logic [1:0]      m_r_resp, s_r_resp;
    logic            s_ar_valid, s_ar_ready, s_r_valid, s_r_ready;
    logic [AW-1:0]   s_ar_addr;

    // Three-master instance
    logic [2:0]      c_ar_valid, c_ar_ready, c_r_valid, c_r_ready;
    logic [3*AW-1:0] c_ar_addr;
    logic [DW-1:0]   c_r_data, c_s_r_data;
    logic [1:0]      c_r_resp, c_s_r_resp;
    logic            c_s_ar_valid, c_s_ar_ready, c_s_r_valid, c_s_r_ready;
    logic [AW-1:0]   c_s_ar_addr;

    axi_rd_arbiter #(.NUM_MST(2), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .m_ar_valid(m_ar_valid), .m_ar_addr(m_ar_addr), .m_ar_ready(m_ar_ready),
        .m_r_valid(m_r_valid), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_ready(m_r_ready),
        .s_ar_valid(s_ar_valid), .s_ar_addr(s_ar_addr), .s_ar_ready(s_ar_ready),
        .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_resp(s_r_resp), .s_r_ready(s_r_ready)
    );

    axi_rd_arbiter #(.NUM_MST(3), .ADDR_W(AW), .DATA_W(DW)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .m_ar_valid(c_ar_valid), .m_ar_addr(c_ar_addr), .m_ar_ready(c_ar_ready),
        .m_r_valid(c_r_valid), .m_r_data(c_r_data), .m_r_resp(c_r_resp), .m_r_ready(c_r_ready),
        .s_ar_valid(c_s_ar_valid), .s_ar_addr(c_s_ar_addr), .s_ar_ready(c_s_ar_ready),
        .s_r_valid(c_s_r_valid), .s_r_data(c_s_r_data), .s_r_resp(c_s_r_resp), .s_r_ready(c_s_r_ready)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  vld;
        logic [31:0] a0, a1;
        logic [1:0]  mrdy;
        logic        sarr, srv;
        logic [31:0] sdata;
        logic [1:0]  sresp;
        logic [1:0]  e_arr;
        logic        e_sav;
        logic [31:0] e_saddr;
        logic [1:0]  e_mrv;
        logic        e_srr;
    } vec_t;

    vec_t tbl[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic rst_v, input logic [1:0] vld, input logic [31:0] a0, input logic [31:0] a1,
        input logic [1:0] mrdy, input logic sarr, input logic srv, input logic [31:0] sdata,
        input logic [1:0] sresp, input logic [1:0] e_arr, input logic e_sav,
        input logic [31:0] e_saddr, input logic [1:0] e_mrv, input logic e_srr);
        vec_t v;
        v.rst = rst_v; v.vld = vld; v.a0 = a0; v.a1 = a1; v.mrdy = mrdy;
        v.sarr = sarr; v.srv = srv; v.sdata = sdata; v.sresp = sresp;
        v.e_arr = e_arr; v.e_sav = e_sav; v.e_saddr = e_saddr; v.e_mrv = e_mrv; v.e_srr = e_srr;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        rst        = v.rst;
        m_ar_valid = v.vld;
        m_ar_addr  = {v.a1, v.a0};
        m_r_ready  = v.mrdy;
        s_ar_ready = v.sarr;
        s_r_valid  = v.srv;
        s_r_data   = v.sdata;
        s_r_resp   = v.sresp;
    endtask

    task automatic build_table();
        logic [31:0] la;
        logic [1:0]  g, v;
        logic [31:0] ga;
        // Reset state, then a single m0 read followed by a spurious slave R beat in ARB.
        tbl.push_back(mk(1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 32'h0, 2'b00, 0));
        tbl.push_back(mk(0, 2'b01, 32'h8000_0000, 0, 2'b11, 1, 0, 0, 0, 2'b01, 0, 32'h0, 2'b00, 0));
        tbl.push_back(mk(0, 2'b00, 32'h8000_0000, 0, 2'b11, 1, 0, 0, 0, 2'b00, 1, 32'h8000_0000, 2'b00, 0));
        tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 1, 1, 32'hDEAD_BEEF, 2'b00, 2'b00, 0, 32'h8000_0000, 2'b01, 1));
        tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 0, 1, 32'h1234, 2'b10, 2'b00, 0, 32'h8000_0000, 2'b00, 0));
        tbl.push_back(mk(1, 2'b00, 0, 0, 2'b11, 0, 0, 0, 0, 2'b00, 0, 32'h8000_0000, 2'b00, 0));
        // Both masters held valid for four transactions, then only m1.
        la = 32'h0;
        for (int t = 0; t < 5; t++) begin
            v  = (t == 4) ? 2'b10 : 2'b11;
            g  = (t == 4) ? 2'b10 : ((t % 2 == 1) ? ALT_G : 2'b01);
            ga = (t == 4) ? 32'h200 : ((t % 2 == 1) ? ALT_A : 32'h100);
            tbl.push_back(mk(0, v, 32'h100, 32'h200, 2'b11, 1, 1, 32'h1000 + t, 2'(t), g, 0, la, 2'b00, 0));
            la = ga;
            tbl.push_back(mk(0, v, 32'h100, 32'h200, 2'b11, 1, 1, 32'h1000 + t, 2'(t), 2'b00, 1, la, 2'b00, 0));
            tbl.push_back(mk(0, v, 32'h100, 32'h200, 2'b11, 1, 1, 32'h2000 + t, 2'(t), 2'b00, 0, la, g, 1));
        end
        // Backpressure: slave AR stalls 5 cycles, m1 withholds R ready 3 cycles; m0 waits meanwhile.
        tbl.push_back(mk(0, 2'b10, 0, 32'h300, 2'b11, 1, 0, 0, 0, 2'b10, 0, la, 2'b00, 0));
        for (int t = 0; t < 5; t++)
            tbl.push_back(mk(0, 2'b01, 32'h100, 32'h300, 2'b11, 0, 1, 32'h77, 0, 2'b00, 1, 32'h300, 2'b00, 0));
        tbl.push_back(mk(0, 2'b01, 32'h100, 32'h300, 2'b11, 1, 0, 0, 0, 2'b00, 1, 32'h300, 2'b00, 0));
        for (int t = 0; t < 3; t++)
            tbl.push_back(mk(0, 2'b01, 32'h100, 32'h300, 2'b01, 1, 1, 32'hCAFE_F00D, 2'b10, 2'b00, 0, 32'h300, 2'b10, 0));
        tbl.push_back(mk(0, 2'b01, 32'h100, 32'h300, 2'b10, 1, 1, 32'hCAFE_F00D, 2'b10, 2'b00, 0, 32'h300, 2'b10, 1));
        tbl.push_back(mk(0, 2'b01, 32'h100, 32'h300, 2'b11, 1, 1, 32'hCAFE_F00D, 2'b10, 2'b01, 0, 32'h300, 2'b00, 0));
        // m0 transaction reaches RESP, reset lands there, then an m1-only request is served.
        tbl.push_back(mk(0, 2'b00, 32'h100, 0, 2'b11, 1, 0, 0, 0, 2'b00, 1, 32'h100, 2'b00, 0));
        tbl.push_back(mk(0, 2'b00, 32'h100, 0, 2'b11, 1, 0, 0, 0, 2'b00, 0, 32'h100, 2'b00, 1));
        tbl.push_back(mk(1, 2'b00, 32'h100, 0, 2'b11, 1, 1, 32'h5555, 2'b01, 2'b00, 0, 32'h100, 2'b01, 1));
        tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 1, 1, 32'h6666, 2'b11, 2'b00, 0, 32'h0, 2'b00, 0));
        tbl.push_back(mk(0, 2'b10, 0, 32'h400, 2'b11, 1, 1, 32'h6666, 2'b00, 2'b10, 0, 32'h0, 2'b00, 0));
        tbl.push_back(mk(0, 2'b00, 0, 32'h400, 2'b11, 1, 1, 32'h6666, 2'b00, 2'b00, 1, 32'h400, 2'b00, 0));
        tbl.push_back(mk(0, 2'b00, 0, 32'h400, 2'b11, 1, 1, 32'h7777, 2'b11, 2'b00, 0, 32'h400, 2'b10, 1));
        tbl.push_back(mk(0, 2'b00, 0, 0, 2'b11, 0, 0, 0, 0, 2'b00, 0, 32'h400, 2'b00, 0));
    endtask

    initial begin
        rst = 1'b1;
        m_ar_valid = '0; m_ar_addr = '0; m_r_ready = '0;
        s_ar_ready = 1'b0; s_r_valid = 1'b0; s_r_data = '0; s_r_resp = '0;
        c_ar_valid = '0; c_ar_addr = '0; c_r_ready = '0;
        c_s_ar_ready = 1'b0; c_s_r_valid = 1'b0; c_s_r_data = '0; c_s_r_resp = '0;
        build_table();
        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            apply(tbl[i]);
            #1;
            check($sformatf("vec%0d", i),
                  128'({m_ar_ready, s_ar_valid, s_ar_addr, m_r_valid, s_r_ready, m_r_data, m_r_resp}),
                  128'({tbl[i].e_arr, tbl[i].e_sav, tbl[i].e_saddr, tbl[i].e_mrv, tbl[i].e_srr,
                        tbl[i].sdata, tbl[i].sresp}));
        end

        // Three masters, pointer at reset value 2, m0 and m2 requesting together.
        @(negedge clk);
        rst = 1'b0;
        c_ar_valid = 3'b101;
        c_ar_addr = {32'hC00, 32'hB00, 32'hA00};
        c_r_ready = 3'b111; c_s_ar_ready = 1'b1; c_s_r_valid = 1'b0;
        #1 check("wrap_arb1", 128'(c_ar_ready), 128'(3'b001));
        @(negedge clk);
        #1 check("wrap_addr1", 128'({c_s_ar_valid, c_s_ar_addr}), 128'({1'b1, 32'hA00}));
        @(negedge clk);
        c_s_r_valid = 1'b1; c_s_r_data = 32'h0A0A_0A0A; c_s_r_resp = 2'b11;
        #1 check("wrap_resp1", 128'({c_r_valid, c_s_r_ready, c_r_data, c_r_resp}),
                 128'({3'b001, 1'b1, 32'h0A0A_0A0A, 2'b11}));
        @(negedge clk);
        c_s_r_valid = 1'b0;
        #1 check("wrap_arb2", 128'(c_ar_ready), 128'(WRAP_G));
        @(negedge clk);
        #1 check("wrap_addr2", 128'({c_s_ar_valid, c_s_ar_addr}), 128'({1'b1, WRAP_A}));
        @(negedge clk);
        c_s_r_valid = 1'b1; c_s_r_data = 32'h0C0C_0C0C; c_s_r_resp = 2'b01;
        #1 check("wrap_resp2", 128'({c_r_valid, c_s_r_ready, c_r_data, c_r_resp}),
                 128'({WRAP_G, 1'b1, 32'h0C0C_0C0C, 2'b01}));
        @(negedge clk);
        c_ar_valid = '0; c_s_r_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
